mst_lpbk_fifo: RTL and testbench

//  Loopback buffer between the master FIFO FSM receive path and the pre-fetch stream source.

---
 rtl/mst_lpbk_fifo.sv | 101 ++++++++++
 tb/tb_mst_lpbk_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mst_lpbk_fifo.sv
// Loopback buffer: captures words received by the master FIFO FSM and replays them
// to the pre-fetch stream source on request, with almost-full back-pressure.
module mst_lpbk_fifo #(
    parameter int          AW           = 9,
    parameter int          AFULL_MARGIN = 8,
    parameter logic [15:0] FILL         = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          rx_vld,
    input  logic [15:0]   rx_dat,
    output logic          rx_afull,
    input  logic          tx_req,
    output logic [15:0]   tx_dat,
    output logic          tx_rdy,
    output logic [AW:0]   level,
    output logic [15:0]   ovf_cnt,
    output logic          udf
);

    localparam logic [AW:0] DEPTH  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] MARGIN = (AW+1)'(AFULL_MARGIN);
    localparam logic [AW:0] ONE    = (AW+1)'(1);

    logic [15:0] mem_q [0:2**AW-1];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_d;
    logic [15:0] tx_dat_q;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;
    logic        udf_q, udf_d;
    logic        afull_q, afull_d;
    logic        full, empty, do_wr, do_rd;

    // Status is taken from the registered pointers only, so a full buffer never
    // accepts a write in the same cycle a read frees a slot.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign do_wr = rx_vld && !full && !flush;
    assign do_rd = tx_req && !empty && !flush;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovf_cnt_d = ovf_cnt_q;
        udf_d     = udf_q;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            ovf_cnt_d = '0;
            udf_d     = 1'b0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + ONE;
            if (do_rd) rd_ptr_d = rd_ptr_q + ONE;
            if (tx_req && empty) udf_d = 1'b1;
            if (rx_vld && full && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
        level_d = wr_ptr_d - rd_ptr_d;
        afull_d = (DEPTH - level_d) <= MARGIN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_cnt_q <= '0;
            udf_q     <= 1'b0;
            afull_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_cnt_q <= ovf_cnt_d;
            udf_q     <= udf_d;
            afull_q   <= afull_d;
        end
    end

    // RAM write port; contents survive reset since the pointers make them unreachable.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= rx_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_dat_q <= 16'h0000;
        end else if (!flush && tx_req) begin
            tx_dat_q <= empty ? FILL : mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    assign level    = wr_ptr_q - rd_ptr_q;
    assign tx_rdy   = (level != '0);
    assign rx_afull = afull_q;
    assign tx_dat   = tx_dat_q;
    assign ovf_cnt  = ovf_cnt_q;
    assign udf      = udf_q;

endmodule

// File: tb/tb_mst_lpbk_fifo.sv
// Directed bench for mst_lpbk_fifo with a 16-word buffer, margin 2 and a distinctive fill word.
module tb_mst_lpbk_fifo;

    localparam int          AW   = 4;
    localparam logic [15:0] FILL = 16'hBEEF;

    logic          clk = 1'b0;
    logic          rst, flush, rx_vld, tx_req;
    logic [15:0]   rx_dat;
    logic          rx_afull, tx_rdy, udf;
    logic [15:0]   tx_dat, ovf_cnt;
    logic [AW:0]   level;

    int n_tests = 0;
    int n_fail  = 0;

    mst_lpbk_fifo #(.AW(AW), .AFULL_MARGIN(2), .FILL(FILL)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rx_vld(rx_vld), .rx_dat(rx_dat), .rx_afull(rx_afull),
        .tx_req(tx_req), .tx_dat(tx_dat), .tx_rdy(tx_rdy),
        .level(level), .ovf_cnt(ovf_cnt), .udf(udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [15:0] dat;
        logic        req;
        logic        fl;
        logic [4:0]  e_lvl;
        logic [15:0] e_tx;
        logic        e_rdy;
        logic        e_afull;
        logic [15:0] e_ovf;
        logic        e_udf;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic drive(input logic vld, input logic [15:0] dat, input logic req, input logic fl);
        rx_vld = vld;
        rx_dat = dat;
        tx_req = req;
        flush  = fl;
        @(posedge clk);
        #1;
        rx_vld = 1'b0;
        tx_req = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vt[0] = '{1'b0, 16'h0000, 1'b1, 1'b0, 5'd0, FILL,     1'b0, 1'b0, 16'd0, 1'b1};
        vt[1] = '{1'b1, 16'h1111, 1'b0, 1'b0, 5'd1, FILL,     1'b1, 1'b0, 16'd0, 1'b1};
        vt[2] = '{1'b1, 16'h2222, 1'b1, 1'b0, 5'd1, 16'h1111, 1'b1, 1'b0, 16'd0, 1'b1};
        vt[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 5'd0, 16'h2222, 1'b0, 1'b0, 16'd0, 1'b1};
        vt[4] = '{1'b1, 16'h3333, 1'b1, 1'b0, 5'd1, FILL,     1'b1, 1'b0, 16'd0, 1'b1};
        vt[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 5'd0, 16'h3333, 1'b0, 1'b0, 16'd0, 1'b1};
        vt[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 5'd0, 16'h3333, 1'b0, 1'b0, 16'd0, 1'b1};
        vt[7] = '{1'b1, 16'h4444, 1'b1, 1'b1, 5'd0, 16'h3333, 1'b0, 1'b0, 16'd0, 1'b0};
        vt[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 5'd0, FILL,     1'b0, 1'b0, 16'd0, 1'b1};
        vt[9] = '{1'b0, 16'h0000, 1'b0, 1'b1, 5'd0, FILL,     1'b0, 1'b0, 16'd0, 1'b0};

        rst = 1'b1; flush = 1'b0; rx_vld = 1'b0; tx_req = 1'b0; rx_dat = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_tx_dat", 32'(tx_dat), 32'h0000);
        chk("rst_tx_rdy", 32'(tx_rdy), 32'd0);
        chk("rst_afull", 32'(rx_afull), 32'd0);
        chk("rst_ovf", 32'(ovf_cnt), 32'd0);
        chk("rst_udf", 32'(udf), 32'd0);
        rst = 1'b0;

        // Underrun, simultaneous access on near-empty buffer, flush behaviour.
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].vld, vt[i].dat, vt[i].req, vt[i].fl);
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(vt[i].e_lvl));
            chk($sformatf("vec%0d_tx_dat", i), 32'(tx_dat), 32'(vt[i].e_tx));
            chk($sformatf("vec%0d_tx_rdy", i), 32'(tx_rdy), 32'(vt[i].e_rdy));
            chk($sformatf("vec%0d_afull", i), 32'(rx_afull), 32'(vt[i].e_afull));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf_cnt), 32'(vt[i].e_ovf));
            chk($sformatf("vec%0d_udf", i), 32'(udf), 32'(vt[i].e_udf));
        end

        // Fill with 16 words, then drain back-to-back.
        do_reset();
        for (int i = 0; i < 16; i++) drive(1'b1, 16'(i + 1), 1'b0, 1'b0);
        chk("t1_level_full", 32'(level), 32'd16);
        chk("t1_tx_rdy", 32'(tx_rdy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b0);
            chk($sformatf("t1_rd%0d", i), 32'(tx_dat), 32'(i + 1));
        end
        chk("t1_level_empty", 32'(level), 32'd0);
        chk("t1_tx_rdy_empty", 32'(tx_rdy), 32'd0);

        // Almost-full threshold and overflow counting.
        do_reset();
        for (int i = 0; i < 13; i++) drive(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
        chk("t2_afull_at13", 32'(rx_afull), 32'd0);
        chk("t2_level13", 32'(level), 32'd13);
        drive(1'b1, 16'h020D, 1'b0, 1'b0);
        chk("t2_afull_at14", 32'(rx_afull), 32'd1);
        chk("t2_level14", 32'(level), 32'd14);
        for (int i = 14; i < 18; i++) drive(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
        chk("t2_level16", 32'(level), 32'd16);
        chk("t2_ovf2", 32'(ovf_cnt), 32'd2);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b0);
            chk($sformatf("t2_rd%0d", i), 32'(tx_dat), 32'h0200 + 32'(i));
        end
        chk("t2_afull_drained", 32'(rx_afull), 32'd0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t2_no_extra_words", 32'(tx_dat), 32'(FILL));
        chk("t2_udf", 32'(udf), 32'd1);

        // Simultaneous read+write when full, then steady state at half full.
        do_reset();
        for (int i = 0; i < 16; i++) drive(1'b1, 16'h4000 + 16'(i), 1'b0, 1'b0);
        drive(1'b1, 16'h4444, 1'b1, 1'b0);
        chk("t4_full_rd", 32'(tx_dat), 32'h4000);
        chk("t4_full_ovf", 32'(ovf_cnt), 32'd1);
        chk("t4_full_level", 32'(level), 32'd15);
        for (int i = 1; i < 8; i++) drive(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t4_half_level", 32'(level), 32'd8);
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, 16'h5000 + 16'(k), 1'b1, 1'b0);
            chk($sformatf("t4_lvl%0d", k), 32'(level), 32'd8);
            chk($sformatf("t4_rd%0d", k), 32'(tx_dat),
                (k < 8) ? 32'h4008 + 32'(k) : 32'h5000 + 32'(k - 8));
        end

        // Pointer wrap: 8-word lead, 1:1 streaming, then drain.
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
        for (int i = 8; i < 40; i++) begin
            drive(1'b1, 16'hA000 + 16'(i), 1'b1, 1'b0);
            chk($sformatf("t5_rd%0d", i - 8), 32'(tx_dat), 32'hA000 + 32'(i - 8));
        end
        chk("t5_level", 32'(level), 32'd8);
        for (int j = 32; j < 40; j++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b0);
            chk($sformatf("t5_rd%0d", j), 32'(tx_dat), 32'hA000 + 32'(j));
        end

        // Flush then reset mid-stream with traffic active.
        do_reset();
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) drive(1'b1, 16'h6000 + 16'(i), 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t6_pre_tx", 32'(tx_dat), 32'h6000);
        chk("t6_pre_ovf", 32'(ovf_cnt), 32'd1);
        chk("t6_pre_udf", 32'(udf), 32'd1);
        drive(1'b1, 16'h7777, 1'b1, 1'b1);
        chk("t6_fl_level", 32'(level), 32'd0);
        chk("t6_fl_ovf", 32'(ovf_cnt), 32'd0);
        chk("t6_fl_udf", 32'(udf), 32'd0);
        chk("t6_fl_tx_hold", 32'(tx_dat), 32'h6000);
        chk("t6_fl_rdy", 32'(tx_rdy), 32'd0);
        chk("t6_fl_afull", 32'(rx_afull), 32'd0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t6_fl_nowrite", 32'(tx_dat), 32'(FILL));
        drive(1'b1, 16'h8000, 1'b0, 1'b0);
        drive(1'b1, 16'h8001, 1'b1, 1'b0);
        chk("t6_pre_rst_tx", 32'(tx_dat), 32'h8000);
        rst = 1'b1; rx_vld = 1'b1; rx_dat = 16'h9999; tx_req = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; rx_vld = 1'b0; tx_req = 1'b0;
        chk("t6_rst_level", 32'(level), 32'd0);
        chk("t6_rst_tx", 32'(tx_dat), 32'h0000);
        chk("t6_rst_ovf", 32'(ovf_cnt), 32'd0);
        chk("t6_rst_udf", 32'(udf), 32'd0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t6_rst_empty_rd", 32'(tx_dat), 32'(FILL));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
